ransac_point_fetch: RTL

Avalon-MM read master that streams sample points out of the 64K×32 on-chip data memory into the RANSAC hardware pipeline. It replaces software copy loops on the NIOS. Given a base word address and a point count, it reads (x, y) word pairs from the memory's second slave port and presents them as a valid/ready point stream with a last flag. Throughput is one point per two clocks, limited by the single read port. Output backpressure is absorbed by a small point FIFO.

---
 rtl/ransac_pkg.sv | 20 ++
 rtl/ransac_point_fifo.sv | 64 ++++++
 rtl/ransac_point_fetch.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ransac_pkg.sv
// Shared types for the RANSAC point fetch path: point record and fetch FSM states.
package ransac_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] x;
        logic signed [DATA_W_DEF-1:0] y;
        logic                         last;
    } point_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/ransac_point_fifo.sv
// Small synchronous point FIFO; head entry and status come straight from flops.
module ransac_point_fifo
    import ransac_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  point_t                   push_data,
    input  logic                     pop,
    output point_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);

    point_t             mem_q [DEPTH];
    point_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     cnt_q, cnt_d;
    logic               do_push, do_pop;

    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        // a push into a full FIFO is only accepted alongside a pop
        do_push  = push && ((cnt_q != (PTR_W+1)'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign occupancy = cnt_q;

endmodule

// File: rtl/ransac_point_fetch.sv
// Avalon-MM read master streaming (x, y) word pairs from data memory as a point stream.
// state    | meaning
// IDLE     | waiting for start
// RUN      | issuing x/y read pairs under FIFO credit
// DRAIN    | all reads issued, waiting for the last handshake
// DONE     | one-cycle done pulse
module ransac_point_fetch
    import ransac_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_y,
    output logic              out_last
);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               cs_q, cs_d, is_y_q, is_y_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d, next_addr_q, next_addr_d;
    logic [CNT_W-1:0]   count_q, count_d, issued_q, issued_d;
    logic               rd_last_q, rd_last_d;
    logic               rx_x_q, rx_x_d, rx_y_q, rx_y_d, rx_last_q, rx_last_d;
    logic [DATA_W-1:0]  x_hold_q, x_hold_d;
    logic [OCC_W-1:0]   in_flight_q, in_flight_d;
    logic               issue_x, room;

    point_t             fifo_head, push_data;
    logic               fifo_full, fifo_empty;
    logic [OCC_W-1:0]   fifo_occ;

    // credit covers both queued points and reads whose y data has not returned yet
    assign room = !fifo_full &&
                  (({1'b0, fifo_occ} + {1'b0, in_flight_q}) < (OCC_W+1)'(FIFO_DEPTH));

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cs_d        = 1'b0;
        is_y_d      = 1'b0;
        mem_addr_d  = mem_addr_q;
        next_addr_d = next_addr_q;
        count_d     = count_q;
        issued_d    = issued_q;
        rd_last_d   = rd_last_q;
        issue_x     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        busy_d      = 1'b1;
                        count_d     = count;
                        cs_d        = 1'b1;
                        mem_addr_d  = base_addr;
                        next_addr_d = base_addr + ADDR_W'(2);
                        issued_d    = CNT_W'(1);
                        rd_last_d   = (count == CNT_W'(1));
                        issue_x     = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (cs_q && !is_y_q) begin
                    cs_d       = 1'b1;
                    is_y_d     = 1'b1;
                    mem_addr_d = mem_addr_q + 1'b1;
                    if (rd_last_q) begin
                        state_d = ST_DRAIN;
                    end
                end else if ((issued_q != count_q) && room) begin
                    cs_d        = 1'b1;
                    mem_addr_d  = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_W'(2);
                    issued_d    = issued_q + 1'b1;
                    rd_last_d   = (issued_q == (count_q - 1'b1));
                    issue_x     = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!fifo_empty && out_ready && fifo_head.last) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rx_x_d      = cs_q && !is_y_q;
        rx_y_d      = cs_q && is_y_q;
        rx_last_d   = rd_last_q;
        x_hold_d    = rx_x_q ? mem_readdata : x_hold_q;
        in_flight_d = in_flight_q + OCC_W'(issue_x) - OCC_W'(rx_y_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            is_y_q      <= 1'b0;
            mem_addr_q  <= '0;
            next_addr_q <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            rd_last_q   <= 1'b0;
            rx_x_q      <= 1'b0;
            rx_y_q      <= 1'b0;
            rx_last_q   <= 1'b0;
            x_hold_q    <= '0;
            in_flight_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
            is_y_q      <= is_y_d;
            mem_addr_q  <= mem_addr_d;
            next_addr_q <= next_addr_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            rd_last_q   <= rd_last_d;
            rx_x_q      <= rx_x_d;
            rx_y_q      <= rx_y_d;
            rx_last_q   <= rx_last_d;
            x_hold_q    <= x_hold_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign push_data = '{x: x_hold_q, y: mem_readdata, last: rx_last_q};

    ransac_point_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (rx_y_q),
        .push_data  (push_data),
        .pop        (out_ready),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .occupancy  (fifo_occ)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_address    = mem_addr_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign out_valid      = !fifo_empty;
    assign out_x          = fifo_head.x;
    assign out_y          = fifo_head.y;
    assign out_last       = fifo_head.last;

endmodule
